// File: rtl/mdio_controller.sv
//------------------------------------------------------------------------------
// Module   : mdio_controller
// Brief    : Serialises one 32-bit MDIO management frame on an MDC = CLK/2
//            clock and captures the 16-bit turnaround-side read data.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdio_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        MDIO_DONE
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WRITE    = 2'd1;
    localparam logic [1:0] c_READ     = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_READ  = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [4:0]  r_bit_cnt;
    logic        r_phase;
    logic [31:0] r_shift;
    logic [15:0] r_shadow;
    logic [15:0] r_rd_data;
    logic        r_is_read;

    logic [1:0]  w_op;
    logic        w_in_frame;
    logic        w_start_ok;
    logic        w_last_bit;
    logic        w_rx_sample;

    assign w_op        = T_DATA[29:28];
    assign w_in_frame  = (r_state == c_WRITE) || (r_state == c_READ);
    assign w_last_bit  = w_in_frame && r_phase && (&r_bit_cnt);
    // Read data is taken on the edge that closes the MDC-high half of bits 16..31.
    assign w_rx_sample = (r_state == c_READ) && r_phase && r_bit_cnt[4];
    assign w_start_ok  = (r_state == c_IDLE) && (w_next_state != c_IDLE);

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (MDIO_START) begin
                    if (w_op == c_OP_WRITE) begin
                        w_next_state = c_WRITE;
                    end else if (w_op == c_OP_READ) begin
                        w_next_state = c_READ;
                    end
                end
            end
            c_WRITE, c_READ: begin
                if (w_last_bit) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Frame datapath: bit counter, MDC phase, transmit and receive shifters
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_bit_cnt <= 5'd0;
            r_phase   <= 1'b0;
            r_shift   <= 32'd0;
            r_shadow  <= 16'd0;
            r_rd_data <= 16'h0000;
            r_is_read <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_shift   <= T_DATA;
                r_bit_cnt <= 5'd0;
                r_phase   <= 1'b0;
                r_is_read <= (w_op == c_OP_READ);
            end else if (w_in_frame) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_shift <= {r_shift[30:0], 1'b0};
                    if (w_last_bit) begin
                        r_bit_cnt <= 5'd0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
            end

            if (w_rx_sample) begin
                r_shadow <= {r_shadow[14:0], MDIO_IN};
            end
            // The final sample bypasses the shadow so RD_DATA is valid in the DONE cycle.
            if (w_rx_sample && (&r_bit_cnt)) begin
                r_rd_data <= {r_shadow[14:0], MDIO_IN};
            end
        end
    end

    //--------------------------------------------------------------------------
    // Output decode
    //--------------------------------------------------------------------------
    always_comb begin
        MDC       = 1'b0;
        MDIO_OUT  = 1'b0;
        MDIO_OE   = 1'b0;
        DATA_RDY  = 1'b0;
        MDIO_DONE = 1'b0;
        case (r_state)
            c_WRITE: begin
                MDC      = r_phase;
                MDIO_OE  = 1'b1;
                MDIO_OUT = r_shift[31];
            end
            c_READ: begin
                MDC      = r_phase;
                MDIO_OE  = ~r_bit_cnt[4];
                MDIO_OUT = ~r_bit_cnt[4] & r_shift[31];
            end
            c_DONE: begin
                MDIO_DONE = 1'b1;
                DATA_RDY  = r_is_read;
            end
            default: begin
                MDC = 1'b0;
            end
        endcase
    end

    assign RD_DATA = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_mdio_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_mdio_controller
// Brief    : Self-checking bench for mdio_controller with a frame-level model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdio_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MDIO_START = 1'b0;
    logic [31:0] T_DATA = 32'd0;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        MDIO_DONE;

    mdio_controller dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDC        (MDC),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .RD_DATA    (RD_DATA),
        .DATA_RDY   (DATA_RDY),
        .MDIO_DONE  (MDIO_DONE)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Frame model: m_k counts cycles since the accepting edge (1..64 bits, 65 done).
    logic        m_busy    = 1'b0;
    int          m_k       = 0;
    logic [31:0] m_frame   = 32'd0;
    logic        m_is_read = 1'b0;
    logic [15:0] m_phy     = 16'd0;
    logic [15:0] m_rd      = 16'd0;
    logic [15:0] next_phy  = 16'd0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_rd   <= 16'd0;
        end else if (m_busy) begin
            if (m_k == 65) begin
                m_busy <= 1'b0;
                m_k    <= 0;
            end else begin
                m_k <= m_k + 1;
                if (m_k == 64 && m_is_read) m_rd <= m_phy;
            end
        end else if (MDIO_START && (T_DATA[29:28] == 2'b01 || T_DATA[29:28] == 2'b10)) begin
            m_busy    <= 1'b1;
            m_k       <= 1;
            m_frame   <= T_DATA;
            m_is_read <= (T_DATA[29:28] == 2'b10);
            m_phy     <= next_phy;
        end
    end

    // PHY side: drives read data over bits 16..31, noise elsewhere.
    logic r_noise = 1'b0;
    logic w_phy_bit;
    always @(negedge CLK) r_noise <= 1'($urandom);
    always_comb begin
        w_phy_bit = r_noise;
        if (m_busy && m_is_read && m_k >= 33 && m_k <= 64)
            w_phy_bit = m_phy[15 - ((m_k - 33) / 2)];
    end
    assign MDIO_IN = w_phy_bit;

    always @(negedge CLK) begin : p_cmp
        logic e_mdc, e_out, e_oe, e_done, e_rdy;
        int   i;
        e_mdc = 1'b0;
        e_out = 1'b0;
        e_oe  = 1'b0;
        if (m_busy && m_k <= 64) begin
            i     = (m_k - 1) / 2;
            e_mdc = ((m_k - 1) % 2) == 1;
            e_oe  = !m_is_read || (i < 16);
            e_out = e_oe ? m_frame[31 - i] : 1'b0;
        end
        e_done = m_busy && (m_k == 65);
        e_rdy  = e_done && m_is_read;
        check("mdc",       32'(MDC),       32'(e_mdc));
        check("mdio_out",  32'(MDIO_OUT),  32'(e_out));
        check("mdio_oe",   32'(MDIO_OE),   32'(e_oe));
        check("mdio_done", 32'(MDIO_DONE), 32'(e_done));
        check("data_rdy",  32'(DATA_RDY),  32'(e_rdy));
        check("rd_data",   32'(RD_DATA),   32'(m_rd));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one start request and observes 70 cycles; optional busy-time start pulse.
    task automatic run_frame(input logic [31:0] frame, input logic [15:0] phy, input int busy_at,
                             output logic [31:0] cap, output int n_mdc, output int n_oe,
                             output int n_done, output int n_rdy, output logic [15:0] rd_at_rdy);
        T_DATA     = frame;
        next_phy   = phy;
        MDIO_START = 1'b1;
        tick();
        MDIO_START = 1'b0;
        T_DATA     = $urandom;
        cap = 32'd0; n_mdc = 0; n_oe = 0; n_done = 0; n_rdy = 0; rd_at_rdy = 16'd0;
        for (int j = 1; j <= 70; j++) begin
            @(negedge CLK);
            if (MDC) begin
                cap = {cap[30:0], MDIO_OUT};
                n_mdc++;
            end
            if (MDIO_OE) n_oe++;
            if (MDIO_DONE) n_done++;
            if (DATA_RDY) begin
                n_rdy++;
                rd_at_rdy = RD_DATA;
            end
            if (j == busy_at) begin
                MDIO_START = 1'b1;
                T_DATA     = 32'h6000_0000;
            end else begin
                MDIO_START = 1'b0;
            end
        end
        tick();
    endtask

    initial begin : p_stim
        logic [31:0] cap;
        logic [15:0] rd, phy, p0, p2;
        logic [31:0] fr;
        int          n_mdc, n_oe, n_done, n_rdy, nd;
        logic [1:0]  op;

        repeat (3) tick();
        check("reset_mdc",  32'(MDC),       32'd0);
        check("reset_oe",   32'(MDIO_OE),   32'd0);
        check("reset_out",  32'(MDIO_OUT),  32'd0);
        check("reset_rd",   32'(RD_DATA),   32'd0);
        check("reset_done", 32'(MDIO_DONE), 32'd0);
        check("reset_rdy",  32'(DATA_RDY),  32'd0);
        RESET = 1'b1;
        tick();

        run_frame(32'h5086_BEEF, 16'h0, 0, cap, n_mdc, n_oe, n_done, n_rdy, rd);
        check("wr_serial", cap, 32'h5086_BEEF);
        check("wr_mdc_cnt", 32'(n_mdc), 32'd32);
        check("wr_oe_cnt", 32'(n_oe), 32'd64);
        check("wr_done", 32'(n_done), 32'd1);
        check("wr_rdy", 32'(n_rdy), 32'd0);

        run_frame(32'h6086_0000, 16'hAAAA, 0, cap, n_mdc, n_oe, n_done, n_rdy, rd);
        check("rd_serial", cap, 32'h6086_0000);
        check("rd_oe_cnt", 32'(n_oe), 32'd32);
        check("rd_done", 32'(n_done), 32'd1);
        check("rd_rdy", 32'(n_rdy), 32'd1);
        check("rd_value", 32'(rd), 32'h0000_AAAA);

        run_frame(32'h4000_0000, 16'h0, 0, cap, n_mdc, n_oe, n_done, n_rdy, rd);
        check("inv00_mdc", 32'(n_mdc), 32'd0);
        check("inv00_oe", 32'(n_oe), 32'd0);
        check("inv00_done", 32'(n_done), 32'd0);
        run_frame(32'h7FFF_FFFF, 16'h0, 0, cap, n_mdc, n_oe, n_done, n_rdy, rd);
        check("inv11_done", 32'(n_done), 32'd0);
        check("inv_rd_hold", 32'(RD_DATA), 32'h0000_AAAA);

        run_frame(32'h5000_1234, 16'h0, 21, cap, n_mdc, n_oe, n_done, n_rdy, rd);
        check("busy_done", 32'(n_done), 32'd1);
        check("busy_rd_hold", 32'(RD_DATA), 32'h0000_AAAA);
        run_frame(32'h6046_0000, 16'h3C5A, 0, cap, n_mdc, n_oe, n_done, n_rdy, rd);
        check("after_busy_rd", 32'(rd), 32'h0000_3C5A);

        // Reset during bit 20 of a read.
        T_DATA = 32'h6086_0000; next_phy = 16'h5555; MDIO_START = 1'b1;
        tick();
        MDIO_START = 1'b0;
        repeat (41) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("mid_rst_mdc", 32'(MDC), 32'd0);
        check("mid_rst_oe", 32'(MDIO_OE), 32'd0);
        check("mid_rst_out", 32'(MDIO_OUT), 32'd0);
        check("mid_rst_done", 32'(MDIO_DONE), 32'd0);
        check("mid_rst_rd", 32'(RD_DATA), 32'd0);
        repeat (2) tick();
        RESET = 1'b1;
        repeat (30) tick();
        check("post_rst_rd", 32'(RD_DATA), 32'd0);
        run_frame(32'h6086_0000, 16'h9B17, 0, cap, n_mdc, n_oe, n_done, n_rdy, rd);
        check("post_rst_read", 32'(rd), 32'h0000_9B17);

        // Back-to-back with START held: read, write, read.
        p0 = 16'h1F2E; p2 = 16'hC3A5; nd = 0;
        T_DATA = 32'h6086_0000; next_phy = p0; MDIO_START = 1'b1;
        tick();
        T_DATA = 32'h5086_1357;
        for (int j = 1; j <= 66; j++) begin
            @(negedge CLK);
            if (MDIO_DONE) nd++;
        end
        tick();
        T_DATA = 32'h60C6_0000; next_phy = p2;
        for (int j = 1; j <= 66; j++) begin
            @(negedge CLK);
            if (MDIO_DONE) nd++;
            if (j == 30) check("b2b_rd_hold", 32'(RD_DATA), 32'(p0));
        end
        tick();
        MDIO_START = 1'b0;
        for (int j = 1; j <= 70; j++) begin
            @(negedge CLK);
            if (MDIO_DONE) nd++;
        end
        tick();
        check("b2b_done_cnt", 32'(nd), 32'd3);
        check("b2b_rd_last", 32'(RD_DATA), 32'(p2));

        // Randomised frames, gaps and busy-time starts.
        for (int n = 0; n < 12; n++) begin
            op  = 2'($urandom);
            fr  = {2'b01, op, 28'($urandom)};
            phy = 16'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_frame(fr, phy, (op == 2'b01 || op == 2'b10) ? int'($urandom_range(2, 64)) : 0,
                      cap, n_mdc, n_oe, n_done, n_rdy, rd);
            check("rnd_done", 32'(n_done), (op == 2'b01 || op == 2'b10) ? 32'd1 : 32'd0);
            if (op == 2'b10) check("rnd_rd", 32'(rd), 32'(phy));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge; MDC is derived from CLK.
REQ-002 RESET  input  1  reset, asynchronous, active-low; one clock domain (CLK) only.
REQ-003 MDIO_START  input  1  request to issue one frame; sampled only in IDLE.
REQ-004 T_DATA  input  32  full frame, MSB first: [31:30] start, [29:28] op (01 write, 10 read), [27:23] PHY addr, [22:18] reg addr, [17:16] turnaround, [15:0] write data.
REQ-005 MDIO_IN  input  1  serial read data returned by the PHY-side receiver.
REQ-006 MDC  output  1  management clock, CLK/2, active only during a frame.
REQ-007 MDIO_OUT  output  1  serial frame bit toward the PHY side.
REQ-008 MDIO_OE  output  1  high while the controller drives MDIO_OUT.
REQ-009 RD_DATA  output  16  last completed read value.
REQ-010 DATA_RDY  output  1  one-cycle pulse: RD_DATA updated.
REQ-011 MDIO_DONE  output  1  one-cycle pulse: frame complete (read or write).

Function
REQ-012 States SHALL be IDLE, WRITE, READ, DONE.
REQ-013 IDLE: MDC=0, MDIO_OE=0, MDIO_OUT=0, DATA_RDY=0, MDIO_DONE=0.
REQ-014 IDLE with MDIO_START=1 at edge c0 and T_DATA[29:28]=01 -> WRITE; =10 -> READ; T_DATA latched into a 32-bit shift register at c0.
REQ-015 IDLE with MDIO_START=1 and op 00 or 11 SHALL stay IDLE, no output change.
REQ-016 Bit i (i=0..31, bit 0 = T_DATA[31]) SHALL occupy cycles 2i+1 (MDC=0) and 2i+2 (MDC=1) after c0; 64 CLK cycles per frame.
REQ-017 MDIO_OUT SHALL change only at the start of the MDC-low phase; stable across every MDC rising edge.
REQ-018 Bit counter 5 bits plus 1 phase bit; counter advances after each MDC-high phase; no wrap inside a frame.
REQ-019 WRITE: MDIO_OE=1 for bits 0..31; all 32 bits driven from the shift register.
REQ-020 READ: MDIO_OE=1 for bits 0..15; MDIO_OE=0 and MDIO_OUT=0 for bits 16..31.
REQ-021 READ: MDIO_IN SHALL be sampled at the CLK edge ending the MDC-high phase of bits 16..31, shifted in MSB first (bit 16 -> RD_DATA[15]) into a shadow register.
REQ-022 After bit 31 -> DONE for exactly one cycle (cycle 65): MDC=0, MDIO_OE=0, MDIO_DONE=1; READ only: RD_DATA <= shadow and DATA_RDY=1 in the same cycle.
REQ-023 DONE -> IDLE unconditionally; MDIO_START during WRITE, READ or DONE SHALL be ignored (not queued).
REQ-024 RD_DATA SHALL hold its value across write frames and ignored starts; it changes only at a READ's DONE cycle or reset.
REQ-025 T_DATA changes after c0 SHALL not affect the frame in progress.

Reset
REQ-026 RESET=0 SHALL immediately force state IDLE, counter 0, phase 0, shift and shadow registers 0, MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, MDIO_DONE=0.
REQ-027 Reset mid-frame SHALL abort the frame with no MDIO_DONE and no RD_DATA update; first frame after release starts from bit 0.

Verification
REQ-028 Write: T_DATA=32'h5086_BEEF, MDIO_START pulse -> MDIO_OUT serialises 0101_0000_1000_0110_1011_1110_1110_1111 on 32 MDC rising edges, MDIO_OE=1 throughout, MDIO_DONE=1 at cycle 65, DATA_RDY=0.
REQ-029 Read: T_DATA=32'h6086_0000, PHY model drives 16'hAAAA on bits 16..31 -> MDIO_OE falls after bit 15, RD_DATA=16'hAAAA with DATA_RDY=MDIO_DONE=1 at cycle 65.
REQ-030 Invalid op: T_DATA=32'h4000_0000 with MDIO_START -> MDC stays 0, MDIO_OE stays 0, no MDIO_DONE over 70 cycles.
REQ-031 Busy start: second MDIO_START at bit 10 of a write -> ignored; exactly one MDIO_DONE; new start after return to IDLE accepted.
REQ-032 Mid-frame reset: RESET=0 during bit 20 of a read -> all outputs 0 at once; RD_DATA stays 16'h0000; next read completes normally.
REQ-033 Back-to-back: MDIO_START held high -> frames start at c0 and c0+66, RD_DATA held between reads across an interleaved write.
